// File: rtl/bitcnt_pipe_if.sv
// Request/result bundle for the pipelined bit-count unit.
// The master drives requests and consumes results; the slave is the unit.
interface bitcnt_pipe_if #(
    parameter int XLEN  = 32,
    parameter int TAG_W = 4
);
    logic             in_valid;
    logic             in_ready;
    logic [1:0]       in_op;
    logic             in_word;
    logic [XLEN-1:0]  rs1;
    logic [TAG_W-1:0] in_tag;
    logic             out_valid;
    logic             out_ready;
    logic [XLEN-1:0]  rd;
    logic [TAG_W-1:0] out_tag;
    logic             out_illegal;

    modport master (
        output in_valid, in_op, in_word, rs1, in_tag, out_ready,
        input  in_ready, out_valid, rd, out_tag, out_illegal
    );

    modport slave (
        input  in_valid, in_op, in_word, rs1, in_tag, out_ready,
        output in_ready, out_valid, rd, out_tag, out_illegal
    );
endinterface

// File: rtl/bitcnt_pipe.sv
// Two-stage CLZ/CTZ/CPOP unit with word mode, valid/ready on both sides.
// Stage 1 reduces each chunk; stage 2 merges chunk results into the count.
module bitcnt_pipe #(
    parameter int XLEN  = 32,
    parameter int TAG_W = 4,
    parameter int CHUNK = 8
) (
    input  logic           clk,
    input  logic           rst,
    bitcnt_pipe_if.slave   bus
);
    localparam int NCH    = XLEN / CHUNK;
    localparam int NCH_W  = 32 / CHUNK;
    localparam int CNT_W  = $clog2(CHUNK + 1);
    localparam int RES_W  = $clog2(XLEN) + 1;
    localparam int IDX_W  = (NCH > 1) ? $clog2(NCH) : 1;

    typedef enum logic [1:0] {
        OP_CLZ  = 2'b00,
        OP_CTZ  = 2'b01,
        OP_CPOP = 2'b10,
        OP_RSVD = 2'b11
    } op_e;

    // Pipeline control
    logic s1_valid;
    logic s2_valid;
    logic s1_adv;
    logic s2_adv;

    assign s2_adv       = !s2_valid || bus.out_ready;
    assign s1_adv       = !s1_valid || s2_adv;
    assign bus.in_ready = s1_adv;

    // Stage 1 combinational chunk reduction
    logic                 word_eff;
    logic [XLEN-1:0]      x_eff;
    logic [CHUNK-1:0]     chunk;
    logic [CNT_W-1:0]     lz;
    logic [CNT_W-1:0]     tz;
    logic [CNT_W-1:0]     pop;
    logic                 seen_lz;
    logic                 seen_tz;
    logic [NCH-1:0]       c_zero;
    logic [CNT_W-1:0]     c_cnt [NCH];
    logic [CNT_W-1:0]     c_pop [NCH];

    always_comb begin
        word_eff = (XLEN == 64) && bus.in_word;
        x_eff    = bus.rs1;
        if (word_eff) begin
            for (int b = 32; b < XLEN; b++) begin
                x_eff[b] = 1'b0;
            end
        end
        chunk   = '0;
        lz      = '0;
        tz      = '0;
        pop     = '0;
        seen_lz = 1'b0;
        seen_tz = 1'b0;
        for (int c = 0; c < NCH; c++) begin
            chunk   = x_eff[c*CHUNK +: CHUNK];
            lz      = '0;
            tz      = '0;
            pop     = '0;
            seen_lz = 1'b0;
            seen_tz = 1'b0;
            for (int b = CHUNK - 1; b >= 0; b--) begin
                if (!seen_lz) begin
                    if (chunk[b]) begin
                        seen_lz = 1'b1;
                    end else begin
                        lz = lz + CNT_W'(1);
                    end
                end
            end
            for (int b = 0; b < CHUNK; b++) begin
                if (!seen_tz) begin
                    if (chunk[b]) begin
                        seen_tz = 1'b1;
                    end else begin
                        tz = tz + CNT_W'(1);
                    end
                end
                pop = pop + CNT_W'(chunk[b]);
            end
            c_zero[c] = (chunk == '0);
            c_cnt[c]  = (op_e'(bus.in_op) == OP_CTZ) ? tz : lz;
            c_pop[c]  = pop;
        end
    end

    // Stage 1 registers
    op_e              s1_op;
    logic             s1_word;
    logic [TAG_W-1:0] s1_tag;
    logic             s1_illegal;
    logic [NCH-1:0]   s1_zero;
    logic [CNT_W-1:0] s1_cnt [NCH];
    logic [CNT_W-1:0] s1_pop [NCH];

    // Stage 2 merge: CLZ walks down from the top active chunk, CTZ walks up from chunk 0
    int               nch_eff;
    logic [IDX_W-1:0] scan_idx;
    logic             scan_done;
    logic [RES_W-1:0] scan_sum;
    logic [RES_W-1:0] pop_sum;
    logic [RES_W-1:0] res;

    always_comb begin
        nch_eff   = s1_word ? NCH_W : NCH;
        scan_idx  = '0;
        scan_done = 1'b0;
        scan_sum  = '0;
        pop_sum   = '0;
        for (int i = 0; i < NCH; i++) begin
            if (i < nch_eff) begin
                scan_idx = (s1_op == OP_CTZ) ? IDX_W'(i) : IDX_W'(nch_eff - 1 - i);
                if (!scan_done) begin
                    scan_sum = scan_sum + RES_W'(s1_cnt[scan_idx]);
                    if (!s1_zero[scan_idx]) begin
                        scan_done = 1'b1;
                    end
                end
                pop_sum = pop_sum + RES_W'(s1_pop[i]);
            end
        end
        case (s1_op)
            OP_CLZ,
            OP_CTZ:  res = scan_sum;
            OP_CPOP: res = pop_sum;
            default: res = '0;
        endcase
    end

    // Stage 2 / output registers
    logic [XLEN-1:0]  s2_rd;
    logic [TAG_W-1:0] s2_tag;
    logic             s2_illegal;

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid   <= 1'b0;
            s2_valid   <= 1'b0;
            s2_rd      <= '0;
            s2_tag     <= '0;
            s2_illegal <= 1'b0;
        end else begin
            if (s1_adv) begin
                s1_valid <= bus.in_valid;
                if (bus.in_valid) begin
                    s1_op      <= op_e'(bus.in_op);
                    s1_word    <= word_eff;
                    s1_tag     <= bus.in_tag;
                    s1_illegal <= (op_e'(bus.in_op) == OP_RSVD);
                    s1_zero    <= c_zero;
                    s1_cnt     <= c_cnt;
                    s1_pop     <= c_pop;
                end
            end
            if (s2_adv) begin
                s2_valid <= s1_valid;
                if (s1_valid) begin
                    s2_rd      <= s1_illegal ? '0 : XLEN'(res);
                    s2_tag     <= s1_tag;
                    s2_illegal <= s1_illegal;
                end
            end
        end
    end

    assign bus.out_valid   = s2_valid;
    assign bus.rd          = s2_rd;
    assign bus.out_tag     = s2_tag;
    assign bus.out_illegal = s2_illegal;
endmodule

// File: tb/tb_bitcnt_pipe.sv
// Directed bench for bitcnt_pipe: one XLEN=32 and one XLEN=64 instance driven in lockstep.
// Table vectors check results and latency; sequences cover backpressure, illegal op and reset.
module tb_bitcnt_pipe;
    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    bitcnt_pipe_if #(.XLEN(32), .TAG_W(4)) bus32 ();
    bitcnt_pipe_if #(.XLEN(64), .TAG_W(4)) bus64 ();

    bitcnt_pipe #(.XLEN(32), .TAG_W(4), .CHUNK(8)) dut32 (.clk(clk), .rst(rst), .bus(bus32));
    bitcnt_pipe #(.XLEN(64), .TAG_W(4), .CHUNK(8)) dut64 (.clk(clk), .rst(rst), .bus(bus64));

    typedef struct {
        logic [1:0]  op;
        logic        word;
        logic [63:0] rs1;
        logic [3:0]  tag;
        logic [63:0] exp32;
        logic [63:0] exp64;
        logic        exp_ill;
    } vec_t;

    vec_t        vecs [19];
    logic [63:0] rnd [8];

    task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic apply_stimulus(input logic valid, input logic [1:0] op, input logic word,
                                  input logic [63:0] rs1, input logic [3:0] tag);
        bus32.in_valid = valid;
        bus32.in_op    = op;
        bus32.in_word  = word;
        bus32.rs1      = rs1[31:0];
        bus32.in_tag   = tag;
        bus64.in_valid = valid;
        bus64.in_op    = op;
        bus64.in_word  = word;
        bus64.rs1      = rs1;
        bus64.in_tag   = tag;
    endtask

    task automatic set_out_ready(input logic r);
        bus32.out_ready = r;
        bus64.out_ready = r;
    endtask

    function automatic int ref_clz(input logic [63:0] v, input int w);
        for (int b = w - 1; b >= 0; b--) begin
            if (v[b]) return w - 1 - b;
        end
        return w;
    endfunction

    // One request, exact two-cycle latency, both widths checked
    task automatic run_vector(input int i);
        vec_t v;
        v = vecs[i];
        @(negedge clk);
        apply_stimulus(1'b1, v.op, v.word, v.rs1, v.tag);
        #1;
        check_output($sformatf("v%0d_in_ready32", i), 64'(bus32.in_ready), 64'd1);
        check_output($sformatf("v%0d_in_ready64", i), 64'(bus64.in_ready), 64'd1);
        @(negedge clk);
        apply_stimulus(1'b0, 2'b00, 1'b0, 64'd0, 4'd0);
        check_output($sformatf("v%0d_early32", i), 64'(bus32.out_valid), 64'd0);
        check_output($sformatf("v%0d_early64", i), 64'(bus64.out_valid), 64'd0);
        @(negedge clk);
        check_output($sformatf("v%0d_valid32", i), 64'(bus32.out_valid), 64'd1);
        check_output($sformatf("v%0d_valid64", i), 64'(bus64.out_valid), 64'd1);
        check_output($sformatf("v%0d_rd32", i), 64'(bus32.rd), v.exp32);
        check_output($sformatf("v%0d_rd64", i), bus64.rd, v.exp64);
        check_output($sformatf("v%0d_tag32", i), 64'(bus32.out_tag), 64'(v.tag));
        check_output($sformatf("v%0d_tag64", i), 64'(bus64.out_tag), 64'(v.tag));
        check_output($sformatf("v%0d_ill32", i), 64'(bus32.out_illegal), 64'(v.exp_ill));
        check_output($sformatf("v%0d_ill64", i), 64'(bus64.out_illegal), 64'(v.exp_ill));
    endtask

    // Stream of 8 CLZ requests with out_ready low for the first 5 cycles
    task automatic run_backpressure();
        int          sent;
        int          got [2];
        int          first [2];
        int          last [2];
        logic        prev_stall [2];
        logic [63:0] prev_rd [2];
        logic [3:0]  prev_tag [2];
        logic        ov [2];
        logic        ir [2];
        logic [63:0] rdv [2];
        logic [3:0]  tgv [2];
        logic        orr;
        logic        fire_in;
        sent = 0;
        for (int d = 0; d < 2; d++) begin
            got[d] = 0; first[d] = -1; last[d] = -1; prev_stall[d] = 1'b0;
            prev_rd[d] = '0; prev_tag[d] = '0;
        end
        for (int cyc = 0; cyc < 40; cyc++) begin
            @(negedge clk);
            orr = (cyc >= 5);
            set_out_ready(orr);
            if (sent < 8) apply_stimulus(1'b1, 2'b00, 1'b0, rnd[sent], 4'(sent));
            else          apply_stimulus(1'b0, 2'b00, 1'b0, 64'd0, 4'd0);
            #1;
            ov[0] = bus32.out_valid; ir[0] = bus32.in_ready; rdv[0] = 64'(bus32.rd); tgv[0] = bus32.out_tag;
            ov[1] = bus64.out_valid; ir[1] = bus64.in_ready; rdv[1] = bus64.rd;      tgv[1] = bus64.out_tag;
            for (int d = 0; d < 2; d++) begin
                if (cyc >= 2 && cyc < 5)
                    check_output($sformatf("bp_in_ready_full_d%0d_c%0d", d, cyc), 64'(ir[d]), 64'd0);
                if (prev_stall[d] && ov[d]) begin
                    check_output($sformatf("bp_rd_stable_d%0d_c%0d", d, cyc), rdv[d], prev_rd[d]);
                    check_output($sformatf("bp_tag_stable_d%0d_c%0d", d, cyc), 64'(tgv[d]), 64'(prev_tag[d]));
                end
                if (ov[d] && orr) begin
                    if (got[d] < 8) begin
                        check_output($sformatf("bp_rd_d%0d_n%0d", d, got[d]), rdv[d],
                                     64'(ref_clz(rnd[got[d]], (d == 0) ? 32 : 64)));
                        check_output($sformatf("bp_tag_d%0d_n%0d", d, got[d]), 64'(tgv[d]), 64'(got[d]));
                    end
                    if (first[d] < 0) first[d] = cyc;
                    last[d] = cyc;
                    got[d]++;
                end
                prev_stall[d] = ov[d] && !orr;
                prev_rd[d]    = rdv[d];
                prev_tag[d]   = tgv[d];
            end
            fire_in = bus32.in_valid && bus32.in_ready;
            @(posedge clk);
            if (fire_in) sent++;
        end
        for (int d = 0; d < 2; d++) begin
            check_output($sformatf("bp_count_d%0d", d), 64'(got[d]), 64'd8);
            check_output($sformatf("bp_span_d%0d", d), 64'(last[d] - first[d]), 64'd7);
        end
    endtask

    initial begin
        vecs[0]  = '{2'b00, 1'b0, 64'h0000_0000_0001_0000, 4'd0,  64'd15, 64'd47, 1'b0};
        vecs[1]  = '{2'b00, 1'b0, 64'h0000_0000_8000_0000, 4'd1,  64'd0,  64'd32, 1'b0};
        vecs[2]  = '{2'b00, 1'b0, 64'h0000_0000_0000_0000, 4'd2,  64'd32, 64'd64, 1'b0};
        vecs[3]  = '{2'b01, 1'b0, 64'h0000_0000_0000_0100, 4'd3,  64'd8,  64'd8,  1'b0};
        vecs[4]  = '{2'b01, 1'b0, 64'h0000_0000_0000_0000, 4'd4,  64'd32, 64'd64, 1'b0};
        vecs[5]  = '{2'b10, 1'b0, 64'h0000_0000_F0F0_0001, 4'd5,  64'd9,  64'd9,  1'b0};
        vecs[6]  = '{2'b10, 1'b0, 64'h0000_0000_FFFF_FFFF, 4'd6,  64'd32, 64'd32, 1'b0};
        vecs[7]  = '{2'b00, 1'b0, 64'h0000_0000_0000_0001, 4'd7,  64'd31, 64'd63, 1'b0};
        vecs[8]  = '{2'b00, 1'b1, 64'hFFFF_FFFF_0000_0001, 4'd8,  64'd31, 64'd31, 1'b0};
        vecs[9]  = '{2'b01, 1'b1, 64'hFFFF_FFFF_0000_0000, 4'd9,  64'd32, 64'd32, 1'b0};
        vecs[10] = '{2'b10, 1'b1, 64'hFFFF_FFFF_0000_000F, 4'd10, 64'd4,  64'd4,  1'b0};
        vecs[11] = '{2'b00, 1'b0, 64'hFFFF_FFFF_0000_0000, 4'd11, 64'd32, 64'd0,  1'b0};
        vecs[12] = '{2'b01, 1'b0, 64'h8000_0000_0000_0000, 4'd12, 64'd32, 64'd63, 1'b0};
        vecs[13] = '{2'b10, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 4'd13, 64'd32, 64'd64, 1'b0};
        vecs[14] = '{2'b00, 1'b1, 64'h0000_0000_0000_0000, 4'd14, 64'd32, 64'd32, 1'b0};
        vecs[15] = '{2'b11, 1'b0, 64'h0000_0000_1234_5678, 4'd5,  64'd0,  64'd0,  1'b1};
        vecs[16] = '{2'b00, 1'b0, 64'h0000_0000_0000_0F00, 4'd15, 64'd20, 64'd52, 1'b0};
        vecs[17] = '{2'b01, 1'b1, 64'h0000_0010_0000_0000, 4'd1,  64'd32, 64'd32, 1'b0};
        vecs[18] = '{2'b01, 1'b0, 64'h0000_0100_0000_0000, 4'd2,  64'd32, 64'd40, 1'b0};
        for (int i = 0; i < 8; i++) begin
            rnd[i] = {$urandom(), $urandom()} >> $urandom_range(0, 63);
        end

        rst = 1'b1;
        apply_stimulus(1'b0, 2'b00, 1'b0, 64'd0, 4'd0);
        set_out_ready(1'b1);
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_output("rst_out_valid32", 64'(bus32.out_valid), 64'd0);
        check_output("rst_out_valid64", 64'(bus64.out_valid), 64'd0);
        check_output("rst_rd64", bus64.rd, 64'd0);
        check_output("rst_tag64", 64'(bus64.out_tag), 64'd0);
        check_output("rst_ill64", 64'(bus64.out_illegal), 64'd0);
        rst = 1'b0;
        @(negedge clk);
        check_output("rst_in_ready32", 64'(bus32.in_ready), 64'd1);
        check_output("rst_in_ready64", 64'(bus64.in_ready), 64'd1);

        for (int i = 0; i < 19; i++) begin
            run_vector(i);
        end

        run_backpressure();

        // Reset with two requests in flight; neither may surface later
        @(negedge clk);
        set_out_ready(1'b0);
        apply_stimulus(1'b1, 2'b10, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 4'd9);
        @(negedge clk);
        apply_stimulus(1'b1, 2'b00, 1'b0, 64'h0000_0000_0000_0001, 4'd10);
        @(negedge clk);
        apply_stimulus(1'b0, 2'b00, 1'b0, 64'd0, 4'd0);
        check_output("mid_full_valid32", 64'(bus32.out_valid), 64'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        check_output("mid_rst_valid32", 64'(bus32.out_valid), 64'd0);
        check_output("mid_rst_valid64", 64'(bus64.out_valid), 64'd0);
        check_output("mid_rst_ready32", 64'(bus32.in_ready), 64'd1);
        check_output("mid_rst_ready64", 64'(bus64.in_ready), 64'd1);
        check_output("mid_rst_rd64", bus64.rd, 64'd0);
        set_out_ready(1'b1);
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            check_output($sformatf("mid_ghost32_c%0d", c), 64'(bus32.out_valid), 64'd0);
            check_output($sformatf("mid_ghost64_c%0d", c), 64'(bus64.out_valid), 64'd0);
        end
        run_vector(0);

        @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
